// File: rtl/con_ff_unit_pkg.sv
// Shared definitions for the CON flip-flop unit: branch condition codes and
// the legal parameter ranges of the unit.
package con_ff_unit_pkg;

  // Branch condition codes as they appear in the IR condition field.
  // With a 2-bit field only the first four codes are reachable.
  typedef enum logic [2:0] {
    COND_ZR = 3'b000,  // operand == 0
    COND_NZ = 3'b001,  // operand != 0
    COND_PL = 3'b010,  // operand >= 0 (zero counts as positive)
    COND_MI = 3'b011,  // operand < 0
    COND_AL = 3'b100,  // always
    COND_NV = 3'b101,  // never
    COND_GT = 3'b110,  // operand > 0
    COND_LE = 3'b111   // operand <= 0
  } cond_e;

  localparam int COND_W_MIN = 2;
  localparam int COND_W_MAX = 3;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 2;

endpackage

// File: rtl/con_ff_unit_if.sv
// Control-unit side bundle of the CON unit: evaluate/clear strobes and
// operands towards the unit, flag, status and performance counters back.
interface con_ff_unit_if #(
  parameter int IR_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              con_in;
  logic              con_clr;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] bus_in;
  logic              cnt_clr;
  logic              con_out;
  logic              con_valid;
  logic              busy;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  ntaken_cnt;

  modport master (
    output con_in, con_clr, ir, bus_in, cnt_clr,
    input  con_out, con_valid, busy, taken_cnt, ntaken_cnt
  );

  modport slave (
    input  con_in, con_clr, ir, bus_in, cnt_clr,
    output con_out, con_valid, busy, taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/con_ff_unit_cond_eval.sv
// Combinational branch-condition evaluator. Tests the operand's sign bit and
// zero-ness against the condition code; all relations are signed via the MSB.
module con_cond_eval
  import con_ff_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COND_W = 2
) (
  input  logic [COND_W-1:0] cond,
  input  logic [DATA_W-1:0] operand,
  output logic              result
);

  logic  sign_s;
  logic  zero_s;
  cond_e code_s;

  assign sign_s = operand[DATA_W-1];
  assign zero_s = (operand == {DATA_W{1'b0}});
  // A 2-bit field zero-extends, so it can only select the four basic codes.
  assign code_s = cond_e'(3'(cond));

  // Condition truth table
  always_comb begin
    result = 1'b0;
    case (code_s)
      COND_ZR: result = zero_s;
      COND_NZ: result = ~zero_s;
      COND_PL: result = ~sign_s;
      COND_MI: result = sign_s;
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      COND_GT: result = ~sign_s & ~zero_s;
      COND_LE: result = sign_s | zero_s;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/con_ff_unit.sv
// CON flip-flop unit: samples the IR condition field and the register under
// test on con_in, evaluates after one or two cycles, holds the registered
// taken flag with a valid bit and counts taken/not-taken results.
module con_ff_unit
  import con_ff_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IR_W     = 32,
  parameter int COND_LSB = 19,
  parameter int COND_W   = 2,
  parameter int LATENCY  = 1,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         clr,
  con_ff_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject configurations the datapath cannot build.
  if (COND_W < COND_W_MIN || COND_W > COND_W_MAX) begin : g_bad_cond_w
    $error("con_ff_unit: COND_W=%0d unsupported (2 or 3)", COND_W);
  end
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("con_ff_unit: LATENCY=%0d unsupported (1 or 2)", LATENCY);
  end
  if (COND_LSB + COND_W > IR_W) begin : g_bad_field
    $error("con_ff_unit: condition field exceeds IR width");
  end

  logic [COND_W-1:0] eval_cond_s;
  logic [DATA_W-1:0] eval_op_s;
  logic              done_s;
  logic              result_s;
  logic              con_out_r;
  logic              con_valid_r;
  logic [CNT_W-1:0]  taken_r;
  logic [CNT_W-1:0]  ntaken_r;

  if (LATENCY == 2) begin : g_lat2
    logic              stage_vld_r;
    logic [COND_W-1:0] stage_cond_r;
    logic [DATA_W-1:0] stage_op_r;

    // Operand capture stage; a new con_in may enter every cycle
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        stage_vld_r  <= 1'b0;
        stage_cond_r <= {COND_W{1'b0}};
        stage_op_r   <= {DATA_W{1'b0}};
      end else begin
        stage_vld_r <= bus.con_in;
        if (bus.con_in) begin
          stage_cond_r <= bus.ir[COND_LSB +: COND_W];
          stage_op_r   <= bus.bus_in;
        end
      end
    end

    assign eval_cond_s = stage_cond_r;
    assign eval_op_s   = stage_op_r;
    assign done_s      = stage_vld_r;
    assign bus.busy    = stage_vld_r;
  end else begin : g_lat1
    assign eval_cond_s = bus.ir[COND_LSB +: COND_W];
    assign eval_op_s   = bus.bus_in;
    assign done_s      = bus.con_in;
    assign bus.busy    = 1'b0;
  end

  con_cond_eval #(
    .DATA_W (DATA_W),
    .COND_W (COND_W)
  ) u_eval (
    .cond    (eval_cond_s),
    .operand (eval_op_s),
    .result  (result_s)
  );

  // CON flag: a completing result has priority over con_clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      con_out_r   <= 1'b0;
      con_valid_r <= 1'b0;
    end else if (done_s) begin
      con_out_r   <= result_s;
      con_valid_r <= 1'b1;
    end else if (bus.con_clr) begin
      con_out_r   <= 1'b0;
      con_valid_r <= 1'b0;
    end
  end

  // Saturating performance counters; cnt_clr swallows a coincident result
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      taken_r  <= {CNT_W{1'b0}};
      ntaken_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr) begin
      taken_r  <= {CNT_W{1'b0}};
      ntaken_r <= {CNT_W{1'b0}};
    end else if (done_s) begin
      if (result_s) begin
        if (taken_r != CNT_MAX) begin
          taken_r <= taken_r + CNT_ONE;
        end
      end else begin
        if (ntaken_r != CNT_MAX) begin
          ntaken_r <= ntaken_r + CNT_ONE;
        end
      end
    end
  end

  assign bus.con_out    = con_out_r;
  assign bus.con_valid  = con_valid_r;
  assign bus.taken_cnt  = taken_r;
  assign bus.ntaken_cnt = ntaken_r;

endmodule
